// File: rtl/gsm_egress_port.sv
// ============================================================================
// Module   : gsm_egress_port
// Brief    : Egress-link consumer: pops gsm cells into a local FIFO, frames
//            packets from header lengths and streams them out as valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gsm_egress_port #(
    parameter int DWIDTH      = 128,
    parameter int FAWIDTH     = 3,
    parameter int MAX_PKT_LEN = 7,
    parameter int LOC_PKT_LEN = 24
) (
    input  logic                 clk_80M,
    input  logic                 clr_80M,
    input  logic                 i_egress_valid,
    output logic                 o_egress_rd,
    input  logic [DWIDTH-1:0]    i_egress_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic [DWIDTH-1:0]    o_tx_data,
    output logic                 o_tx_sop,
    output logic                 o_tx_eop,
    output logic [31:0]          o_pkt_cnt,
    output logic [15:0]          o_err_cnt,
    output logic [FAWIDTH:0]     o_fifo_level
);

    localparam int                     c_depth_i = 2 ** FAWIDTH;
    localparam logic [FAWIDTH:0]       c_depth   = c_depth_i[FAWIDTH:0];
    localparam logic [FAWIDTH:0]       c_lvl_one = (FAWIDTH+1)'(1);
    localparam logic [FAWIDTH-1:0]     c_ptr_one = FAWIDTH'(1);
    localparam logic [MAX_PKT_LEN-1:0] c_len_one = MAX_PKT_LEN'(1);
    localparam logic [MAX_PKT_LEN-1:0] c_len_0   = '0;

    typedef enum logic [0:0] {
        S_HDR  = 1'b0,
        S_BODY = 1'b1
    } state_t;

    logic [DWIDTH-1:0]      r_mem [c_depth_i];
    logic [FAWIDTH-1:0]     r_wptr;
    logic [FAWIDTH-1:0]     r_rptr;
    logic [FAWIDTH:0]       r_level;
    state_t                 r_state;
    logic [MAX_PKT_LEN-1:0] r_rem;
    logic                   r_tx_valid;
    logic [DWIDTH-1:0]      r_tx_data;
    logic                   r_tx_sop;
    logic                   r_tx_eop;
    logic [31:0]            r_pkt_cnt;
    logic [15:0]            r_err_cnt;

    logic                   w_full;
    logic                   w_wr;
    logic                   w_pop;
    logic                   w_xfer;
    logic                   w_drop;
    logic [DWIDTH-1:0]      w_head;
    logic [MAX_PKT_LEN-1:0] w_len;

    assign w_full  = (r_level == c_depth);
    assign w_wr    = i_egress_valid & ~w_full;
    // A pop feeds the output stage, so it waits for that stage to be free
    assign w_pop   = (r_level != '0) & (~r_tx_valid | i_tx_ready);
    assign w_xfer  = r_tx_valid & i_tx_ready;
    assign w_head  = r_mem[r_rptr];
    assign w_len   = w_head[LOC_PKT_LEN +: MAX_PKT_LEN];
    assign w_drop  = w_pop & (r_state == S_HDR) & (w_len == c_len_0);

    assign o_egress_rd  = w_wr;
    assign o_tx_valid   = r_tx_valid;
    assign o_tx_data    = r_tx_data;
    assign o_tx_sop     = r_tx_sop;
    assign o_tx_eop     = r_tx_eop;
    assign o_pkt_cnt    = r_pkt_cnt;
    assign o_err_cnt    = r_err_cnt;
    assign o_fifo_level = r_level;

    always_ff @(posedge clk_80M) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_egress_data;
        end
    end

    always_ff @(posedge clk_80M) begin
        if (clr_80M) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_state    <= S_HDR;
            r_rem      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_sop   <= 1'b0;
            r_tx_eop   <= 1'b0;
            r_pkt_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (w_wr && !w_pop) begin
                r_level <= r_level + c_lvl_one;
            end else if (!w_wr && w_pop) begin
                r_level <= r_level - c_lvl_one;
            end

            if (w_xfer) begin
                r_tx_valid <= 1'b0;
            end
            if (w_xfer && r_tx_eop) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_drop && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end

            // Zero-length headers are consumed from the FIFO but never loaded
            if (w_pop && !w_drop) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_head;
                case (r_state)
                    S_HDR: begin
                        r_tx_sop <= 1'b1;
                        if (w_len == c_len_one) begin
                            r_tx_eop <= 1'b1;
                        end else begin
                            r_tx_eop <= 1'b0;
                            r_rem    <= w_len - c_len_one;
                            r_state  <= S_BODY;
                        end
                    end
                    default: begin
                        r_tx_sop <= 1'b0;
                        if (r_rem == c_len_one) begin
                            r_tx_eop <= 1'b1;
                            r_state  <= S_HDR;
                        end else begin
                            r_tx_eop <= 1'b0;
                        end
                        r_rem <= r_rem - c_len_one;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gsm_egress_port.sv
// ============================================================================
// Module   : tb_gsm_egress_port
// Brief    : Directed self-checking bench for gsm_egress_port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gsm_egress_port;

    localparam int DW  = 128;
    localparam int FAW = 3;
    localparam int MPL = 7;
    localparam int LOC = 24;

    logic            clk_80M = 1'b0;
    logic            clr_80M;
    logic            i_egress_valid;
    logic            o_egress_rd;
    logic [DW-1:0]   i_egress_data;
    logic            o_tx_valid;
    logic            i_tx_ready;
    logic [DW-1:0]   o_tx_data;
    logic            o_tx_sop;
    logic            o_tx_eop;
    logic [31:0]     o_pkt_cnt;
    logic [15:0]     o_err_cnt;
    logic [FAW:0]    o_fifo_level;

    always #5 clk_80M = ~clk_80M;

    gsm_egress_port #(
        .DWIDTH      (DW),
        .FAWIDTH     (FAW),
        .MAX_PKT_LEN (MPL),
        .LOC_PKT_LEN (LOC)
    ) u_dut (
        .clk_80M        (clk_80M),
        .clr_80M        (clr_80M),
        .i_egress_valid (i_egress_valid),
        .o_egress_rd    (o_egress_rd),
        .i_egress_data  (i_egress_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_tx_data      (o_tx_data),
        .o_tx_sop       (o_tx_sop),
        .o_tx_eop       (o_tx_eop),
        .o_pkt_cnt      (o_pkt_cnt),
        .o_err_cnt      (o_err_cnt),
        .o_fifo_level   (o_fifo_level)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        int            cyc;
    } xfer_t;

    xfer_t         mon_q[$];
    logic [DW-1:0] src_q[$];
    int            n_vec = 0;
    int            n_miss = 0;
    int            cyc = 0;
    int            rd_cnt = 0;
    bit            pop_pending = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_sop;
    logic          prev_eop;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkcell(input int len, input int id);
        logic [DW-1:0] c;
        c          = '0;
        c[127:96]  = 32'hCE11_0000 + id;
        c[95:64]   = ~id;
        c[23:0]    = id[23:0];
        c[LOC +: MPL] = len[MPL-1:0];
        return c;
    endfunction

    task automatic refresh_src();
        i_egress_valid = (src_q.size() > 0);
        i_egress_data  = (src_q.size() > 0) ? src_q[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk_80M);
        #2;
    endtask

    // Upstream FWFT source: a pop seen on the last negedge retires the head
    always @(posedge clk_80M) begin
        cyc++;
        #1;
        if (pop_pending && src_q.size() > 0) begin
            void'(src_q.pop_front());
        end
        refresh_src();
    end

    always @(negedge clk_80M) begin
        pop_pending = o_egress_rd;
        if (o_egress_rd) begin
            rd_cnt++;
        end
        if (prev_stall && !clr_80M) begin
            chk("stall_valid", o_tx_valid, 1);
            chk("stall_data", o_tx_data, prev_d);
            chk("stall_sop", o_tx_sop, prev_sop);
            chk("stall_eop", o_tx_eop, prev_eop);
        end
        if (o_tx_valid && i_tx_ready && !clr_80M) begin
            mon_q.push_back('{o_tx_data, o_tx_sop, o_tx_eop, cyc});
        end
        prev_stall = o_tx_valid & ~i_tx_ready & ~clr_80M;
        prev_d     = o_tx_data;
        prev_sop   = o_tx_sop;
        prev_eop   = o_tx_eop;
    end

    task automatic do_reset();
        tick();
        clr_80M    = 1'b1;
        i_tx_ready = 1'b0;
        src_q.delete();
        refresh_src();
        tick();
        tick();
        clr_80M = 1'b0;
        mon_q.delete();
        rd_cnt = 0;
    endtask

    task automatic wait_out(input int n, input int maxc);
        int t;
        t = 0;
        while (mon_q.size() < n && t < maxc) begin
            @(negedge clk_80M);
            t++;
        end
        chk("wait_out", mon_q.size() >= n, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"},    o_egress_rd, 0);
        chk({tag, "_valid"}, o_tx_valid, 0);
        chk({tag, "_sop"},   o_tx_sop, 0);
        chk({tag, "_eop"},   o_tx_eop, 0);
        chk({tag, "_data"},  o_tx_data, 0);
        chk({tag, "_pkt"},   o_pkt_cnt, 0);
        chk({tag, "_err"},   o_err_cnt, 0);
        chk({tag, "_level"}, o_fifo_level, 0);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        int neop;
        clr_80M        = 1'b1;
        i_tx_ready     = 1'b0;
        i_egress_valid = 1'b0;
        i_egress_data  = '0;

        // Reset state, then a single-cell packet
        do_reset();
        @(negedge clk_80M);
        chk_zero("reset");
        tick();
        src_q.push_back(mkcell(1, 1));
        refresh_src();
        i_tx_ready = 1'b1;
        @(negedge clk_80M);
        chk("t1_rd_hi", o_egress_rd, 1);
        chk("t1_valid_lat0", o_tx_valid, 0);
        @(negedge clk_80M);
        chk("t1_rd_lo", o_egress_rd, 0);
        chk("t1_valid_lat1", o_tx_valid, 0);
        @(negedge clk_80M);
        chk("t1_valid", o_tx_valid, 1);
        chk("t1_sop", o_tx_sop, 1);
        chk("t1_eop", o_tx_eop, 1);
        chk("t1_data", o_tx_data, mkcell(1, 1));
        @(negedge clk_80M);
        chk("t1_pkt", o_pkt_cnt, 1);
        chk("t1_valid_after", o_tx_valid, 0);

        // L=4 back-to-back; body length fields are zero and must be ignored
        do_reset();
        src_q.push_back(mkcell(4, 10));
        for (int i = 11; i <= 13; i++) src_q.push_back(mkcell(0, i));
        refresh_src();
        i_tx_ready = 1'b1;
        wait_out(4, 50);
        repeat (3) @(negedge clk_80M);
        chk("t2_count", mon_q.size(), 4);
        if (mon_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_data", mon_q[i].d, (i == 0) ? mkcell(4, 10) : mkcell(0, 10 + i));
                chk("t2_sop", mon_q[i].sop, (i == 0));
                chk("t2_eop", mon_q[i].eop, (i == 3));
            end
            chk("t2_b2b", mon_q[3].cyc - mon_q[0].cyc, 3);
        end
        chk("t2_pkt", o_pkt_cnt, 1);

        // Fill with output stalled: 8 in FIFO plus 1 held in the output stage
        do_reset();
        src_q.push_back(mkcell(20, 20));
        for (int i = 1; i < 20; i++) src_q.push_back(mkcell((i * 37) % 128, 20 + i));
        refresh_src();
        repeat (20) @(negedge clk_80M);
        chk("t3_level", o_fifo_level, 8);
        chk("t3_rd_full", o_egress_rd, 0);
        chk("t3_valid", o_tx_valid, 1);
        chk("t3_held_sop", o_tx_sop, 1);
        chk("t3_accepted", rd_cnt, 9);
        tick();
        i_tx_ready = 1'b1;
        wait_out(20, 100);
        repeat (3) @(negedge clk_80M);
        chk("t3_count", mon_q.size(), 20);
        if (mon_q.size() >= 20) begin
            for (int i = 0; i < 20; i++) begin
                chk("t3_data", mon_q[i].d, (i == 0) ? mkcell(20, 20) : mkcell((i * 37) % 128, 20 + i));
                chk("t3_eop", mon_q[i].eop, (i == 19));
            end
        end
        chk("t3_pkt", o_pkt_cnt, 1);

        // Zero-length header is dropped, following L=2 packet intact
        do_reset();
        src_q.push_back(mkcell(0, 40));
        src_q.push_back(mkcell(2, 41));
        src_q.push_back(mkcell(5, 42));
        refresh_src();
        i_tx_ready = 1'b1;
        wait_out(2, 50);
        repeat (3) @(negedge clk_80M);
        chk("t4_count", mon_q.size(), 2);
        if (mon_q.size() >= 2) begin
            chk("t4_data0", mon_q[0].d, mkcell(2, 41));
            chk("t4_sop0", mon_q[0].sop, 1);
            chk("t4_eop0", mon_q[0].eop, 0);
            chk("t4_data1", mon_q[1].d, mkcell(5, 42));
            chk("t4_sop1", mon_q[1].sop, 0);
            chk("t4_eop1", mon_q[1].eop, 1);
        end
        chk("t4_err", o_err_cnt, 1);
        chk("t4_pkt", o_pkt_cnt, 1);

        // Saturation: 1 + 65540 drops must pin the error counter
        tick();
        for (int i = 0; i < 65540; i++) src_q.push_back(mkcell(0, i));
        refresh_src();
        t = 0;
        while ((src_q.size() > 0 || o_fifo_level != 0) && t < 70000) begin
            @(negedge clk_80M);
            t++;
        end
        chk("t4_drain", t < 70000, 1);
        repeat (3) @(negedge clk_80M);
        chk("t4_err_sat", o_err_cnt, 16'hFFFF);
        chk("t4_no_out", mon_q.size(), 2);

        // L=127 under random backpressure
        do_reset();
        src_q.push_back(mkcell(127, 50));
        for (int i = 1; i < 127; i++) src_q.push_back(mkcell((i * 11) % 128, 50 + i));
        refresh_src();
        t = 0;
        while (mon_q.size() < 127 && t < 3000) begin
            tick();
            i_tx_ready = 1'($urandom_range(0, 1));
            t++;
        end
        tick();
        i_tx_ready = 1'b1;
        repeat (5) @(negedge clk_80M);
        chk("t5_count", mon_q.size(), 127);
        if (mon_q.size() >= 127) begin
            neop = 0;
            for (int i = 0; i < 127; i++) begin
                chk("t5_data", mon_q[i].d, (i == 0) ? mkcell(127, 50) : mkcell((i * 11) % 128, 50 + i));
                chk("t5_sop", mon_q[i].sop, (i == 0));
                if (mon_q[i].eop) neop++;
            end
            chk("t5_last_eop", mon_q[126].eop, 1);
            chk("t5_eop_total", neop, 1);
        end
        chk("t5_pkt", o_pkt_cnt, 1);

        // Reset in the middle of an L=5 packet
        do_reset();
        src_q.push_back(mkcell(5, 60));
        for (int i = 1; i < 5; i++) src_q.push_back(mkcell(3, 60 + i));
        refresh_src();
        i_tx_ready = 1'b1;
        wait_out(2, 20);
        tick();
        i_tx_ready = 1'b0;
        tick();
        clr_80M = 1'b1;
        src_q.delete();
        refresh_src();
        @(negedge clk_80M);
        @(negedge clk_80M);
        chk_zero("t6_clr");
        neop = 0;
        foreach (mon_q[i]) if (mon_q[i].eop) neop++;
        chk("t6_no_eop", neop, 0);
        tick();
        clr_80M = 1'b0;
        mon_q.delete();
        src_q.push_back(mkcell(1, 70));
        refresh_src();
        i_tx_ready = 1'b1;
        wait_out(1, 20);
        repeat (2) @(negedge clk_80M);
        if (mon_q.size() >= 1) begin
            chk("t6_data", mon_q[0].d, mkcell(1, 70));
            chk("t6_sop", mon_q[0].sop, 1);
            chk("t6_eop", mon_q[0].eop, 1);
        end
        chk("t6_pkt", o_pkt_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
